// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Default widths here match the top-level parameter defaults.
package ifu_pkg;

  localparam int IFU_WORD_SIZE = 16;
  localparam int IFU_ADDR_WIDTH = 16;
  localparam logic ACCESS_WORD = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HALT
  } state_e;

  typedef struct packed {
    logic [IFU_WORD_SIZE-1:0]  data;
    logic [IFU_ADDR_WIDTH-1:0] pc;
    logic                      err;
  } entry_t;

endpackage

// File: rtl/instruction_prefetch_unit_if.sv
// Memory-side request bus and decode-side fetch handshake
// for the instruction prefetch unit.
interface ifu_mem_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_en;
  logic                  mem_access_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_done;
  logic                  mem_err;
  logic [WORD_SIZE-1:0]  mem_data;

  modport master (
    output mem_en, mem_access_size, mem_addr,
    input  mem_done, mem_err, mem_data
  );
  modport slave (
    input  mem_en, mem_access_size, mem_addr,
    output mem_done, mem_err, mem_data
  );
endinterface

interface ifu_fetch_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [WORD_SIZE-1:0]  fetch_data;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fetch_err;

  modport master (
    output fetch_valid, fetch_data, fetch_pc, fetch_err,
    input  fetch_ready
  );
  modport slave (
    input  fetch_valid, fetch_data, fetch_pc, fetch_err,
    output fetch_ready
  );
endinterface

// File: rtl/ifu_queue.sv
// Synchronous DEPTH-entry FIFO for prefetched words.
// Flush wins over push and pop in the same cycle.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type ent_t = entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  ent_t                   din,
  output ent_t                   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);

  ent_t mem_q [DEPTH];
  ent_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + (PW+1)'(do_push)
            - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full = (cnt_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Autonomous instruction prefetcher feeding decode from a small queue.
// Define IFU_PERF_CNT_EN to add fetch_count/flush_count outputs.
module instruction_prefetch_unit
  import ifu_pkg::*;
#(
  parameter int WORD_SIZE = IFU_WORD_SIZE,
  parameter int ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  ifu_mem_if.master             mem,
  ifu_fetch_if.master           fetch,
  output logic                  int_ret
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [15:0]           flush_count
`endif
);
  localparam logic [ADDR_WIDTH-1:0] PC_INC =
    ADDR_WIDTH'(WORD_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] PC_MARK = '1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WORD_SIZE-1:0]  data;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  err;
  } word_ent_t;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic int_ret_q, int_ret_d;
  logic issue, resp, q_push, q_pop;
  logic q_empty, q_full;
  logic [CW-1:0] q_count;
  word_ent_t q_din, q_dout;

  // A redirect in IDLE issues straight to the new address.
  assign issue_pc = redirect ? redirect_pc : next_pc_q;
  assign issue = (state_q == IDLE) & en
               & (issue_pc != PC_MARK)
               & (redirect | (q_count < CW'(DEPTH)));
  assign resp = mem.mem_done | mem.mem_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      next_pc_q <= RESET_PC;
      addr_q <= '0;
      int_ret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      next_pc_q <= next_pc_d;
      addr_q <= addr_d;
      int_ret_q <= int_ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = REQ;
      REQ: begin
        if (redirect) begin
          state_d = resp ? IDLE : DRAIN;
        end else if (mem.mem_err) begin
          state_d = HALT;
        end else if (mem.mem_done) begin
          state_d = IDLE;
        end
      end
      DRAIN: if (resp) state_d = IDLE;
      HALT: if (redirect) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = issue ? issue_pc : addr_q;
    next_pc_d = next_pc_q;
    if (redirect) begin
      next_pc_d = redirect_pc;
    end else if ((state_q == REQ) & mem.mem_done
                 & ~mem.mem_err) begin
      next_pc_d = next_pc_q + PC_INC;
    end
    q_push = (state_q == REQ) & resp & ~redirect & ~q_full;
    q_pop = ~q_empty & fetch.fetch_ready;
    q_din.data = mem.mem_err ? '0 : mem.mem_data;
    q_din.pc = addr_q;
    q_din.err = mem.mem_err;
    int_ret_d = ~redirect & (next_pc_q == PC_MARK)
              & q_empty & (state_q == IDLE);
  end

  ifu_queue #(
    .DEPTH (DEPTH),
    .ent_t (word_ent_t)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign mem.mem_en = (state_q == REQ) | (state_q == DRAIN);
  assign mem.mem_access_size = ACCESS_WORD;
  assign mem.mem_addr = addr_q;
  assign fetch.fetch_valid = ~q_empty;
  assign fetch.fetch_data = q_dout.data;
  assign fetch.fetch_pc = q_dout.pc;
  assign fetch.fetch_err = q_dout.err;
  assign int_ret = int_ret_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [15:0] flcnt_q, flcnt_d;
  logic flush_hit;

  // Flush counts only when a queued or in-flight word is lost.
  assign flush_hit = redirect
                   & ((q_count != '0) | (state_q == REQ));

  always_comb begin
    fcnt_d = fcnt_q;
    flcnt_d = flcnt_q;
    if (q_push & (fcnt_q != '1)) fcnt_d = fcnt_q + 32'd1;
    if (flush_hit & (flcnt_q != '1)) flcnt_d = flcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      flcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      flcnt_q <= flcnt_d;
    end
  end

  assign fetch_count = fcnt_q;
  assign flush_count = flcnt_q;
`endif

endmodule
